// File: rtl/tx_intf_s_axis_to_pl_if.sv
// AXI-Stream link from the PS MM2S DMA into the TX packer.
// The master drives the data and qualifiers; the slave returns tready.
interface tx_intf_s_axis_to_pl_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_intf_s_axis_to_pl.sv
// TX DMA unpacker: splits the header word off the MM2S stream, forwards payload words,
// polices length/tlast consistency, aborts stalled packets and raises a delayed completion IRQ.
module tx_intf_s_axis_to_pl #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int TIMEOUT_WIDTH          = 13
) (
  input  logic                                clk,
  input  logic                                rstn,
  tx_intf_s_axis_to_pl_if.slave               s_axis,
  input  logic                                tx_hold,
  input  logic                                ds_ready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   data_to_tx,
  output logic                                data_valid_to_tx,
  output logic [15:0]                         pkt_len,
  output logic [7:0]                          pkt_rate,
  output logic [1:0]                          pkt_queue,
  output logic                                hdr_valid,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_dma_symbol,
  output logic                                len_err,
  output logic                                tlast_timeout,
  input  logic                                timeout_enable,
  input  logic [TIMEOUT_WIDTH-1:0]            timeout_top,
  input  logic                                tsf_pulse_1M,
  input  logic [14:0]                         count_top,
  output logic                                tx_pkt_intr
);

  typedef enum logic [2:0] {
    ST_WAIT_HDR = 3'd0,
    ST_PAYLOAD  = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DONE     = 3'd3,
    ST_RST_WAIT = 3'd4
  } state_t;

  typedef enum logic {
    IR_IDLE  = 1'b0,
    IR_COUNT = 1'b1
  } intr_state_t;

  state_t                              state_q, state_d;
  intr_state_t                         intr_state_q, intr_state_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   word_cnt_q, word_cnt_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_sym_q, num_sym_d;
  logic [TIMEOUT_WIDTH-1:0]            timer_q, timer_d;
  logic [2:0]                          rst_cnt_q, rst_cnt_d;
  logic [15:0]                         pkt_len_q, pkt_len_d;
  logic [7:0]                          pkt_rate_q, pkt_rate_d;
  logic [1:0]                          pkt_queue_q, pkt_queue_d;
  logic                                hdr_valid_q, hdr_valid_d;
  logic                                len_err_q, len_err_d;
  logic                                tlast_timeout_q, tlast_timeout_d;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic                                data_valid_q, data_valid_d;
  logic [14:0]                         intr_cnt_q, intr_cnt_d;
  logic                                intr_q, intr_d;

  logic                                tready_s;
  logic                                beat_s;
  logic                                timeout_s;
  logic                                done_s;
  logic                                last_word_s;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   hdr_words_s;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   hdr_frac_s;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   hdr_nsym_s;

  // Ready is gated by reset so no beat can be consumed while the block is held in reset.
  always_comb begin
    tready_s = 1'b0;
    if (!rstn) begin
      tready_s = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_HDR: tready_s = !tx_hold;
        ST_PAYLOAD:  tready_s = ds_ready;
        ST_DRAIN:    tready_s = 1'b1;
        default:     tready_s = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = tready_s;
  assign beat_s        = s_axis.tvalid && tready_s;
  assign timeout_s     = timeout_enable && (timer_q > timeout_top);
  assign done_s        = (state_q == ST_DONE);
  assign last_word_s   = ((word_cnt_q + MAX_BIT_NUM_DMA_SYMBOL'(1'b1)) == num_sym_q);

  // Payload words = ceil(len / 8); the 13-bit quotient is zero-extended before the round-up.
  assign hdr_words_s = MAX_BIT_NUM_DMA_SYMBOL'(s_axis.tdata[15:3]);
  assign hdr_frac_s  = MAX_BIT_NUM_DMA_SYMBOL'(|s_axis.tdata[2:0]);
  assign hdr_nsym_s  = hdr_words_s + hdr_frac_s;

  // Next-state logic for the packet FSM and the independent interrupt-delay FSM.
  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    num_sym_d       = num_sym_q;
    timer_d         = timer_q;
    rst_cnt_d       = rst_cnt_q;
    pkt_len_d       = pkt_len_q;
    pkt_rate_d      = pkt_rate_q;
    pkt_queue_d     = pkt_queue_q;
    hdr_valid_d     = 1'b0;
    len_err_d       = 1'b0;
    tlast_timeout_d = 1'b0;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    intr_state_d    = intr_state_q;
    intr_cnt_d      = intr_cnt_q;
    intr_d          = 1'b0;

    case (state_q)
      ST_WAIT_HDR: begin
        if (beat_s) begin
          pkt_len_d   = s_axis.tdata[15:0];
          pkt_rate_d  = s_axis.tdata[23:16];
          pkt_queue_d = s_axis.tdata[25:24];
          num_sym_d   = hdr_nsym_s;
          hdr_valid_d = 1'b1;
          word_cnt_d  = '0;
          timer_d     = '0;
          if (s_axis.tlast) begin
            if (hdr_nsym_s == '0) begin
              state_d = ST_DONE;
            end else begin
              len_err_d = 1'b1;
              state_d   = ST_WAIT_HDR;
            end
          end else if (hdr_nsym_s == '0) begin
            len_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_WAIT_HDR;
        end
      end

      ST_PAYLOAD: begin
        if (beat_s) begin
          data_d       = s_axis.tdata;
          data_valid_d = 1'b1;
          word_cnt_d   = word_cnt_q + MAX_BIT_NUM_DMA_SYMBOL'(1'b1);
          timer_d      = '0;
          if (last_word_s) begin
            if (s_axis.tlast) begin
              state_d = ST_DONE;
            end else begin
              len_err_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (s_axis.tlast) begin
            len_err_d = 1'b1;
            state_d   = ST_WAIT_HDR;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (timeout_s) begin
          tlast_timeout_d = 1'b1;
          rst_cnt_d       = '0;
          state_d         = ST_RST_WAIT;
        end else if (tsf_pulse_1M && !(&timer_q)) begin
          timer_d = timer_q + TIMEOUT_WIDTH'(1'b1);
        end else begin
          timer_d = timer_q;
        end
      end

      ST_DRAIN: begin
        if (beat_s) begin
          timer_d = '0;
          if (s_axis.tlast) begin
            state_d = ST_WAIT_HDR;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (timeout_s) begin
          tlast_timeout_d = 1'b1;
          rst_cnt_d       = '0;
          state_d         = ST_RST_WAIT;
        end else if (tsf_pulse_1M && !(&timer_q)) begin
          timer_d = timer_q + TIMEOUT_WIDTH'(1'b1);
        end else begin
          timer_d = timer_q;
        end
      end

      ST_DONE: begin
        state_d = ST_WAIT_HDR;
      end

      // Hold the stream off for eight cycles while the driver resets the DMA.
      ST_RST_WAIT: begin
        if (rst_cnt_q == 3'd7) begin
          state_d = ST_WAIT_HDR;
        end else begin
          rst_cnt_d = rst_cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_WAIT_HDR;
      end
    endcase

    // A completion arriving mid-count restarts the delay, coalescing into one interrupt.
    case (intr_state_q)
      IR_IDLE: begin
        if (done_s) begin
          intr_state_d = IR_COUNT;
          intr_cnt_d   = '0;
        end else begin
          intr_state_d = IR_IDLE;
        end
      end
      IR_COUNT: begin
        if (done_s) begin
          intr_cnt_d = '0;
        end else if (intr_cnt_q == count_top) begin
          intr_d       = 1'b1;
          intr_state_d = IR_IDLE;
        end else begin
          intr_cnt_d = intr_cnt_q + 15'd1;
        end
      end
      default: begin
        intr_state_d = IR_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_WAIT_HDR;
      intr_state_q    <= IR_IDLE;
      word_cnt_q      <= '0;
      num_sym_q       <= '0;
      timer_q         <= '0;
      rst_cnt_q       <= '0;
      pkt_len_q       <= '0;
      pkt_rate_q      <= '0;
      pkt_queue_q     <= '0;
      hdr_valid_q     <= 1'b0;
      len_err_q       <= 1'b0;
      tlast_timeout_q <= 1'b0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      intr_cnt_q      <= '0;
      intr_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      intr_state_q    <= intr_state_d;
      word_cnt_q      <= word_cnt_d;
      num_sym_q       <= num_sym_d;
      timer_q         <= timer_d;
      rst_cnt_q       <= rst_cnt_d;
      pkt_len_q       <= pkt_len_d;
      pkt_rate_q      <= pkt_rate_d;
      pkt_queue_q     <= pkt_queue_d;
      hdr_valid_q     <= hdr_valid_d;
      len_err_q       <= len_err_d;
      tlast_timeout_q <= tlast_timeout_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      intr_cnt_q      <= intr_cnt_d;
      intr_q          <= intr_d;
    end
  end

  assign data_to_tx       = data_q;
  assign data_valid_to_tx = data_valid_q;
  assign pkt_len          = pkt_len_q;
  assign pkt_rate         = pkt_rate_q;
  assign pkt_queue        = pkt_queue_q;
  assign hdr_valid        = hdr_valid_q;
  assign num_dma_symbol   = num_sym_q;
  assign len_err          = len_err_q;
  assign tlast_timeout    = tlast_timeout_q;
  assign tx_pkt_intr      = intr_q;

endmodule

// File: tb/tb_tx_intf_s_axis_to_pl.sv
// Directed self-checking bench for tx_intf_s_axis_to_pl: one task per scenario,
// expected values worked out by hand from the header fields and beat timing.
module tb_tx_intf_s_axis_to_pl;

  logic        clk;
  logic        rstn;
  logic        tx_hold;
  logic        ds_ready;
  logic [63:0] data_to_tx;
  logic        data_valid_to_tx;
  logic [15:0] pkt_len;
  logic [7:0]  pkt_rate;
  logic [1:0]  pkt_queue;
  logic        hdr_valid;
  logic [13:0] num_dma_symbol;
  logic        len_err;
  logic        tlast_timeout;
  logic        timeout_enable;
  logic [12:0] timeout_top;
  logic        tsf_pulse_1M;
  logic [14:0] count_top;
  logic        tx_pkt_intr;

  int checks;
  int errors;
  int cyc;

  // Monitor tallies, written only by the monitor process.
  int          hdr_cnt, len_err_cnt, tmo_cnt, intr_cnt, last_intr_cyc;
  logic [63:0] dv_data[$];
  int          dv_cyc[$];

  tx_intf_s_axis_to_pl_if #(.DATA_WIDTH(64)) s_axis ();

  tx_intf_s_axis_to_pl dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_axis           (s_axis),
    .tx_hold          (tx_hold),
    .ds_ready         (ds_ready),
    .data_to_tx       (data_to_tx),
    .data_valid_to_tx (data_valid_to_tx),
    .pkt_len          (pkt_len),
    .pkt_rate         (pkt_rate),
    .pkt_queue        (pkt_queue),
    .hdr_valid        (hdr_valid),
    .num_dma_symbol   (num_dma_symbol),
    .len_err          (len_err),
    .tlast_timeout    (tlast_timeout),
    .timeout_enable   (timeout_enable),
    .timeout_top      (timeout_top),
    .tsf_pulse_1M     (tsf_pulse_1M),
    .count_top        (count_top),
    .tx_pkt_intr      (tx_pkt_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid_to_tx === 1'b1) begin
      dv_data.push_back(data_to_tx);
      dv_cyc.push_back(cyc);
    end
    if (hdr_valid === 1'b1) hdr_cnt <= hdr_cnt + 1;
    if (len_err === 1'b1) len_err_cnt <= len_err_cnt + 1;
    if (tlast_timeout === 1'b1) tmo_cnt <= tmo_cnt + 1;
    if (tx_pkt_intr === 1'b1) begin
      intr_cnt      <= intr_cnt + 1;
      last_intr_cyc <= cyc;
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [15:0] len, input logic [7:0] rate,
                                         input logic [1:0] queue);
    return {38'h0, queue, rate, len};
  endfunction

  // Present one beat and wait (bounded) until it is accepted; returns the cycle of the accepting edge.
  task automatic drive_beat(input logic [63:0] d, input logic l, output int edge_cyc);
    int waited;
    waited = 0;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    while (s_axis.tready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (s_axis.tready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: tready=%b after %0d cycles, required 1", s_axis.tready, waited);
    end
    @(posedge clk);
    #1;
    edge_cyc      = cyc;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle(3);
    @(negedge clk);
    checks++;
    if ({hdr_valid, data_valid_to_tx, len_err, tlast_timeout, tx_pkt_intr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 00000",
               {hdr_valid, data_valid_to_tx, len_err, tlast_timeout, tx_pkt_intr});
    end
    checks++;
    if ({pkt_len, pkt_rate, pkt_queue, num_dma_symbol} !== 40'h0 || data_to_tx !== 64'h0) begin
      errors++;
      $display("FAIL reset_fields: len=%h rate=%h q=%h nsym=%h data=%h, required 0",
               pkt_len, pkt_rate, pkt_queue, num_dma_symbol, data_to_tx);
    end
    checks++;
    if (s_axis.tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b, required 0", s_axis.tready);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_hdr_tready: got %b, required 1", s_axis.tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int h0, i0, q0, b;
    int bc[3];
    logic [63:0] w[3];
    w[0] = 64'hA1A1_0000_0000_0001;
    w[1] = 64'hB2B2_0000_0000_0002;
    w[2] = 64'hC3C3_0000_0000_0003;
    h0 = hdr_cnt; i0 = intr_cnt; q0 = dv_data.size();
    count_top = 15'd4;
    // Upper header bits carry junk that must be ignored.
    drive_beat(64'hABCD_1234_050B_0014, 1'b0, b);
    for (int i = 0; i < 3; i++) drive_beat(w[i], (i == 2), bc[i]);
    idle(10);
    @(negedge clk);
    checks++;
    if (hdr_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL basic_hdr_valid: got %0d pulses, required 1", hdr_cnt - h0);
    end
    checks++;
    if (pkt_len !== 16'd20 || pkt_rate !== 8'h0B || pkt_queue !== 2'd1) begin
      errors++;
      $display("FAIL basic_hdr_fields: len=%0d rate=%h q=%0d, required 20 0b 1",
               pkt_len, pkt_rate, pkt_queue);
    end
    checks++;
    if (num_dma_symbol !== 14'd3) begin
      errors++;
      $display("FAIL basic_num_dma_symbol: got %0d, required 3", num_dma_symbol);
    end
    checks++;
    if (dv_data.size() - q0 !== 3) begin
      errors++;
      $display("FAIL basic_word_count: got %0d, required 3", dv_data.size() - q0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dv_data[q0+i] !== w[i] || dv_cyc[q0+i] !== bc[i]) begin
          errors++;
          $display("FAIL basic_word%0d: got %h at cyc %0d, required %h at cyc %0d",
                   i, dv_data[q0+i], dv_cyc[q0+i], w[i], bc[i]);
        end
      end
    end
    checks++;
    if (intr_cnt - i0 !== 1 || last_intr_cyc !== bc[2] + 6) begin
      errors++;
      $display("FAIL basic_intr: got %0d at cyc %0d, required 1 at cyc %0d",
               intr_cnt - i0, last_intr_cyc, bc[2] + 6);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ds_stall;
    int e0, q0, b, w, i, bad;
    logic tr;
    logic [63:0] wd[2];
    wd[0] = 64'h1111_2222_3333_4444;
    wd[1] = 64'h5555_6666_7777_8888;
    e0 = len_err_cnt; q0 = dv_data.size();
    drive_beat(mk_hdr(16'd16, 8'h03, 2'd2), 1'b0, b);
    w = 0; i = 0; bad = 0;
    while (w < 2 && i < 20) begin
      ds_ready      = (i % 2 == 0);
      s_axis.tdata  = wd[w];
      s_axis.tlast  = (w == 1);
      s_axis.tvalid = 1'b1;
      @(negedge clk);
      tr = s_axis.tready;
      if (tr !== ds_ready) bad++;
      @(posedge clk);
      #1;
      if (tr === 1'b1) w++;
      i++;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    ds_ready      = 1'b1;
    checks++;
    if (bad !== 0 || w !== 2) begin
      errors++;
      $display("FAIL stall_tready_follow: %0d mismatched cycles, %0d words taken, required 0 and 2",
               bad, w);
    end
    idle(10);
    @(negedge clk);
    checks++;
    if (dv_data.size() - q0 !== 2) begin
      errors++;
      $display("FAIL stall_word_count: got %0d, required 2", dv_data.size() - q0);
    end else begin
      checks++;
      if (dv_data[q0] !== wd[0] || dv_data[q0+1] !== wd[1]) begin
        errors++;
        $display("FAIL stall_order: got %h %h, required %h %h",
                 dv_data[q0], dv_data[q0+1], wd[0], wd[1]);
      end
    end
    checks++;
    if (len_err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL stall_len_err: got %0d, required 0", len_err_cnt - e0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_early_tlast;
    int e0, i0, q0, b;
    e0 = len_err_cnt; i0 = intr_cnt; q0 = dv_data.size();
    drive_beat(mk_hdr(16'd24, 8'h01, 2'd0), 1'b0, b);
    drive_beat(64'hE000_0000_0000_0001, 1'b0, b);
    drive_beat(64'hE000_0000_0000_0002, 1'b1, b);
    idle(10);
    @(negedge clk);
    checks++;
    if (dv_data.size() - q0 !== 2 || dv_data[$] !== 64'hE000_0000_0000_0002) begin
      errors++;
      $display("FAIL early_words: got %0d words last %h, required 2 last e000000000000002",
               dv_data.size() - q0, dv_data[$]);
    end
    checks++;
    if (len_err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL early_len_err: got %0d, required 1", len_err_cnt - e0);
    end
    checks++;
    if (intr_cnt - i0 !== 0) begin
      errors++;
      $display("FAIL early_no_intr: got %0d, required 0", intr_cnt - i0);
    end
    checks++;
    if (s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL early_back_to_wait_hdr: tready=%b, required 1", s_axis.tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain;
    int e0, i0, q0, h0, b;
    e0 = len_err_cnt; i0 = intr_cnt; q0 = dv_data.size(); h0 = hdr_cnt;
    drive_beat(mk_hdr(16'd8, 8'h02, 2'd3), 1'b0, b);
    drive_beat(64'hD000_0000_0000_0001, 1'b0, b);
    drive_beat(64'hD000_0000_0000_0002, 1'b0, b);
    drive_beat(64'hD000_0000_0000_0003, 1'b1, b);
    idle(10);
    @(negedge clk);
    checks++;
    if (dv_data.size() - q0 !== 1 || dv_data[$] !== 64'hD000_0000_0000_0001) begin
      errors++;
      $display("FAIL drain_words: got %0d words last %h, required 1 last d000000000000001",
               dv_data.size() - q0, dv_data[$]);
    end
    checks++;
    if (len_err_cnt - e0 !== 1 || hdr_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL drain_len_err_hdr: len_err %0d hdr %0d, required 1 1",
               len_err_cnt - e0, hdr_cnt - h0);
    end
    checks++;
    if (intr_cnt - i0 !== 0 || s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL drain_intr_tready: intr %0d tready %b, required 0 1",
               intr_cnt - i0, s_axis.tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout;
    int b, ticks, tick_cyc, t_cyc, zeros;
    logic seen;
    timeout_enable = 1'b1;
    timeout_top    = 13'd5;
    drive_beat(mk_hdr(16'd64, 8'h04, 2'd1), 1'b0, b);
    drive_beat(64'hF000_0000_0000_0001, 1'b0, b);
    drive_beat(64'hF000_0000_0000_0002, 1'b0, b);
    ticks = 0; tick_cyc = 0; t_cyc = 0; seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tsf_pulse_1M = (k % 10 == 9);
      if (tsf_pulse_1M) begin
        ticks++;
        tick_cyc = cyc;
      end
      @(negedge clk);
      if (tlast_timeout === 1'b1) begin
        seen  = 1'b1;
        t_cyc = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    tsf_pulse_1M = 1'b0;
    checks++;
    if (!seen || ticks !== 6 || t_cyc !== tick_cyc + 2) begin
      errors++;
      $display("FAIL timeout_pulse: seen=%b ticks=%0d cyc=%0d, required 1 6 %0d",
               seen, ticks, t_cyc, tick_cyc + 2);
    end
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_axis.tready === 1'b0) zeros++;
      @(negedge clk);
    end
    checks++;
    if (zeros !== 8 || s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rst_wait: %0d stalled cycles then tready=%b, required 8 then 1",
               zeros, s_axis.tready);
    end
    timeout_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_len;
    int h0, i0, q0, e0, b, bad;
    h0 = hdr_cnt; i0 = intr_cnt; q0 = dv_data.size(); e0 = len_err_cnt;
    count_top = 15'd0;
    drive_beat(mk_hdr(16'd0, 8'h07, 2'd2), 1'b1, b);
    idle(6);
    @(negedge clk);
    checks++;
    if (hdr_cnt - h0 !== 1 || dv_data.size() - q0 !== 0 || len_err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL zero_len_flow: hdr %0d words %0d len_err %0d, required 1 0 0",
               hdr_cnt - h0, dv_data.size() - q0, len_err_cnt - e0);
    end
    checks++;
    if (intr_cnt - i0 !== 1 || last_intr_cyc !== b + 2) begin
      errors++;
      $display("FAIL zero_len_intr: got %0d at cyc %0d, required 1 at cyc %0d",
               intr_cnt - i0, last_intr_cyc, b + 2);
    end
    checks++;
    if (pkt_len !== 16'd0 || num_dma_symbol !== 14'd0 || pkt_rate !== 8'h07) begin
      errors++;
      $display("FAIL zero_len_fields: len=%0d nsym=%0d rate=%h, required 0 0 07",
               pkt_len, num_dma_symbol, pkt_rate);
    end
    @(posedge clk);
    #1;
    tx_hold       = 1'b1;
    s_axis.tdata  = mk_hdr(16'd0, 8'h07, 2'd2);
    s_axis.tlast  = 1'b1;
    s_axis.tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_axis.tready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    tx_hold       = 1'b0;
    idle(2);
    @(negedge clk);
    checks++;
    if (bad !== 0 || hdr_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL tx_hold_block: %0d ready cycles, hdr %0d, required 0 and 1", bad, hdr_cnt - h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_packet;
    int e0, t0, i0, q0, b;
    e0 = len_err_cnt; t0 = tmo_cnt; i0 = intr_cnt; q0 = dv_data.size();
    drive_beat(mk_hdr(16'd24, 8'h09, 2'd1), 1'b0, b);
    drive_beat(64'h7777_0000_0000_0001, 1'b0, b);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(6);
    @(negedge clk);
    checks++;
    if (len_err_cnt - e0 !== 0 || tmo_cnt - t0 !== 0 || intr_cnt - i0 !== 0
        || dv_data.size() - q0 !== 1) begin
      errors++;
      $display("FAIL midreset_pulses: len_err %0d tmo %0d intr %0d words %0d, required 0 0 0 1",
               len_err_cnt - e0, tmo_cnt - t0, intr_cnt - i0, dv_data.size() - q0);
    end
    checks++;
    if (pkt_len !== 16'd0 || num_dma_symbol !== 14'd0 || s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: len=%0d nsym=%0d tready=%b, required 0 0 1",
               pkt_len, num_dma_symbol, s_axis.tready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    hdr_cnt = 0; len_err_cnt = 0; tmo_cnt = 0; intr_cnt = 0; last_intr_cyc = 0;
    rstn = 1'b0; tx_hold = 1'b0; ds_ready = 1'b1;
    timeout_enable = 1'b0; timeout_top = 13'd0; tsf_pulse_1M = 1'b0; count_top = 15'd4;
    s_axis.tdata = 64'h0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    test_reset();
    test_basic();
    test_ds_stall();
    test_early_tlast();
    test_drain();
    test_timeout();
    test_zero_len();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_intf_s_axis_to_pl.md
Name: tx_intf_s_axis_to_pl

Overview:
TX-direction counterpart of the RX DMA packer. Consumes a 64-bit AXI-Stream from the PS MM2S DMA: one header word carrying length, rate and queue, then the payload words. Splits the header out to the TX PHY control path and forwards payload words to the TX data path, one registered cycle later. Enforces length/tlast consistency, recovers from stalled DMA with a 1 µs-based timeout, and raises a delayed per-packet completion interrupt.

Parameters:
C_S00_AXIS_TDATA_WIDTH, 64, stream and payload word width
MAX_BIT_NUM_DMA_SYMBOL, 14, width of payload word counters
TIMEOUT_WIDTH, 13, width of timeout counter and top value

Ports:
clk  in  1  clock
rstn  in  1  reset
s_axis_tdata  in  64  DMA stream data
s_axis_tvalid  in  1  DMA stream valid
s_axis_tready  out  1  stream ready (combinational)
s_axis_tlast  in  1  DMA end of packet
tx_hold  in  1  1 = do not accept a new header
ds_ready  in  1  TX data path can accept a payload word
data_to_tx  out  64  registered payload word
data_valid_to_tx  out  1  data_to_tx valid, 1-cycle pulse per word
pkt_len  out  16  header length in bytes, held until next header
pkt_rate  out  8  header rate, held
pkt_queue  out  2  header queue index, held
hdr_valid  out  1  1-cycle pulse when header is latched
num_dma_symbol  out  14  expected payload words for current packet
len_err  out  1  1-cycle pulse on length/tlast mismatch
tlast_timeout  out  1  1-cycle pulse on timeout abort
timeout_enable  in  1  enables timeout abort
timeout_top  in  13  timeout threshold in µs
tsf_pulse_1M  in  1  1 µs tick
count_top  in  15  interrupt delay in clk cycles
tx_pkt_intr  out  1  1-cycle completion interrupt

Behaviour:
- Reset: rstn is synchronous, active-low. All outputs go to 0 and the FSM enters WAIT_HDR.
- A beat is defined as tvalid && tready.
- tready per state: WAIT_HDR = !tx_hold; PAYLOAD = ds_ready; DRAIN = 1; all other states = 0.
- WAIT_HDR, on a beat:
  - Latch pkt_len = tdata[15:0], pkt_rate = tdata[23:16], pkt_queue = tdata[25:24]. Bits [63:26] are ignored.
  - num_dma_symbol = pkt_len[15:3] + (pkt_len[2:0] != 0). Zero-extend the 13-bit term to 14 bits before the add.
  - Pulse hdr_valid on the next cycle and clear word_cnt and the timer.
  - Header tlast with num_dma_symbol == 0 → DONE.
  - Header tlast with num_dma_symbol > 0 → pulse len_err, go to WAIT_HDR.
  - No tlast with num_dma_symbol == 0 → pulse len_err, go to DRAIN.
  - Otherwise → PAYLOAD.
- PAYLOAD, on each beat:
  - data_to_tx <= tdata; data_valid_to_tx <= 1 on the following cycle; word_cnt++.
  - Last expected word (word_cnt == num_dma_symbol-1) with tlast → DONE.
  - Last expected word without tlast → pulse len_err, go to DRAIN. That word is still forwarded.
  - tlast before the last expected word → pulse len_err, go to WAIT_HDR. That word is still forwarded.
- DRAIN: discard beats and forward nothing. On tlast → WAIT_HDR. No interrupt is raised.
- DONE: lasts 1 cycle. Arms the interrupt delay, then → WAIT_HDR.
- Timer:
  - In PAYLOAD and DRAIN, the timer increments on tsf_pulse_1M and clears on every beat.
  - If timer > timeout_top and timeout_enable: pulse tlast_timeout, go to RST_WAIT.
- RST_WAIT: 8 cycles with tready = 0, then → WAIT_HDR. Any later tail of the aborted packet is treated as a new header; this is acceptable because the driver resets the DMA on timeout.
- Interrupt delay FSM, independent of the main FSM:
  - IDLE: waits for DONE.
  - COUNT: counts 0..count_top and pulses tx_pkt_intr when count == count_top. count_top = 0 gives the pulse 1 cycle after entering COUNT.
  - A DONE that arrives while COUNT is active restarts the count, so only one interrupt is raised.
- data_valid_to_tx is never high without a corresponding PAYLOAD beat. ds_ready low in PAYLOAD stalls the stream with no data loss.
- Reset asserted mid-packet aborts immediately with no pulses. The rest of the stream is treated as a new header.

Test Plan:
- Header len=20, rate=0x0B, queue=1, then 3 words with tlast on the 3rd, ds_ready=1 → hdr_valid once; num_dma_symbol=3; 3 data_valid_to_tx pulses, each 1 cycle after its beat; tx_pkt_intr count_top+2 cycles after the last beat.
- len=16, ds_ready toggled 1/0 every cycle → tready follows ds_ready; exactly 2 words out in order; no len_err.
- len=24, tlast on the 2nd payload word → 2 words forwarded, len_err pulse, back to WAIT_HDR, no tx_pkt_intr.
- len=8, 3 payload words with tlast on the 3rd → 1 word forwarded, len_err, remaining 2 words drained, no interrupt.
- len=64, stop tvalid after 2 words, timeout_top=5, tick every 10 cycles → tlast_timeout after the 6th tick; tready=0 for 8 cycles; then WAIT_HDR.
- Header len=0 with tlast → hdr_valid, no data, interrupt raised; the same header with tx_hold=1 → tready=0, header not consumed.
